// File: rtl/dmem_controller.sv
// rtl/dmem_controller.sv - data-memory req/ack access controller with stall and timeout
//
// Turns the datapath's zero-latency DM port into a registered req/ack handshake
// toward a variable-latency memory, stalling the datapath until the access ends.
// Optional build macro: DMEM_ALIGN_CHECK_EN (rejects non-8-byte-aligned accesses).
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   DM_addr/DM_writeData           access address / store data from datapath
//   DM_writeEnable/DM_readEnable   store / load request from datapath
//   DM_readData                    registered load data to writeback
//   stall                          freezes PC and register writeback while high
//   mem_req/mem_we/mem_addr/mem_wdata  registered request toward memory
//   mem_ack/mem_rdata              one-cycle completion pulse and read data
//   bus_error                      one-cycle pulse when the memory never answers
//   misalign                       one-cycle pulse on a rejected misaligned access
module dmem_controller #(
  parameter int N       = 64,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         DM_writeEnable,
  input  logic         DM_readEnable,
  output logic [N-1:0] DM_readData,
  output logic         stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic         bus_error,
  output logic         misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  // Last counter value still allowed to wait for mem_ack.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         req_q, req_d;
  logic         we_q, we_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic         be_q, be_d;
  logic         mis_q, mis_d;

  logic access;
  logic misaligned;

  assign access = DM_readEnable | DM_writeEnable;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (DM_addr[2:0] != 3'b000);
`else
  assign misaligned = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (misaligned) begin
            // Rejected without touching memory; a misaligned load returns zero.
            mis_d   = 1'b1;
            state_d = S_DONE;
            if (!DM_writeEnable) rdata_d = '0;
          end else begin
            // Write enable dominates, so read+write together is a store.
            req_d   = 1'b1;
            we_d    = DM_writeEnable;
            addr_d  = DM_addr;
            wdata_d = DM_writeData;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        // Ack is checked first so it wins over a timeout in the same cycle.
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (!we_q) rdata_d = mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          be_d    = 1'b1;
          state_d = S_DONE;
          if (!we_q) rdata_d = '0;
        end
      end
      S_DONE: begin
        // Enables still high here belong to the retiring instruction.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Combinational outputs
  always_comb begin
    stall = 1'b0;
    case (state_q)
      S_IDLE:  stall = access;
      S_REQ:   stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign DM_readData = rdata_q;
  assign bus_error   = be_q;
  assign misalign    = mis_q;

endmodule

// File: tb/tb_dmem_controller.sv
// tb/tb_dmem_controller.sv - self-checking bench for dmem_controller
module tb_dmem_controller;

  localparam int N       = 64;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] DM_addr;
  logic [N-1:0] DM_writeData;
  logic         DM_writeEnable;
  logic         DM_readEnable;
  logic [N-1:0] DM_readData;
  logic         stall;
  logic         mem_req;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_ack;
  logic [N-1:0] mem_rdata;
  logic         bus_error;
  logic         misalign;

  always #5 clk = ~clk;

  dmem_controller #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .DM_writeEnable (DM_writeEnable),
    .DM_readEnable  (DM_readEnable),
    .DM_readData    (DM_readData),
    .stall          (stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .bus_error      (bus_error),
    .misalign       (misalign)
  );

  typedef struct {
    logic         re;
    logic         we;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic [N-1:0] rdata;
    int           ack_at;     // REQ cycle carrying mem_ack, 0 = never
    int           exp_stall;
    int           exp_req;
    logic [N-1:0] exp_rd;
    int           exp_be;
    int           exp_mis;
  } vec_t;

  typedef struct {
    logic         we;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
  } req_t;

  vec_t  vecs[7];
  req_t  req_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string tag      = "reset";

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", tag, name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   stall_cnt = 0;
    int   req_cnt   = 0;
    int   be_cnt    = 0;
    int   mis_cnt   = 0;
    bit   done      = 0;
    req_t cur;
    cur = '{1'b0, '0, '0};
    tag = $sformatf("vec%0d", idx);
    @(posedge clk); #1;
    DM_readEnable  = v.re;
    DM_writeEnable = v.we;
    DM_addr        = v.addr;
    DM_writeData   = v.wdata;
    if (v.exp_req > 0) req_q.push_back('{v.we, v.addr, v.wdata});
    #1;
    for (int c = 0; c < 64; c++) begin
      if (!stall) begin
        done = 1;
        break;
      end
      stall_cnt++;
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          if (req_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s/scoreboard: got unexpected mem_req expected none", tag);
          end else begin
            cur = req_q.pop_front();
          end
        end
        chk("mem_we", {{(N-1){1'b0}}, mem_we}, {{(N-1){1'b0}}, cur.we});
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_wdata", mem_wdata, cur.wdata);
        mem_ack   = (req_cnt == v.ack_at);
        mem_rdata = (req_cnt == v.ack_at) ? v.rdata : ~v.rdata;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (bus_error) be_cnt++;
      if (misalign) mis_cnt++;
      #1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s/stall_bound: got stall still high after 64 cycles expected release", tag);
    end
    // Now in the DONE cycle, enables still held.
    chk("stall_cycles", N'(stall_cnt), N'(v.exp_stall));
    chk("req_cycles", N'(req_cnt), N'(v.exp_req));
    chk("DM_readData", DM_readData, v.exp_rd);
    chk("bus_error_pulses", N'(be_cnt), N'(v.exp_be));
    chk("misalign_pulses", N'(mis_cnt), N'(v.exp_mis));
    @(posedge clk); #1;
    DM_readEnable  = 1'b0;
    DM_writeEnable = 1'b0;
    #1;
    chk("idle_stall", {{(N-1){1'b0}}, stall}, '0);
    chk("done_no_restart", {{(N-1){1'b0}}, mem_req}, '0);
    chk("bus_error_clear", {{(N-1){1'b0}}, bus_error}, '0);
  endtask

  initial begin
    int be_seen;
    vecs[0] = '{1'b1, 1'b0, 64'h40, 64'h0, 64'hDEADBEEF, 3, 4, 3, 64'hDEADBEEF, 0, 0};
    vecs[1] = '{1'b0, 1'b1, 64'h08, 64'h1234, 64'h9999, 1, 2, 1, 64'hDEADBEEF, 0, 0};
    vecs[2] = '{1'b1, 1'b0, 64'h10, 64'h0, 64'h1111, 0, 17, 16, 64'h0, 1, 0};
    vecs[3] = '{1'b1, 1'b1, 64'h18, 64'hAA, 64'h5555, 2, 3, 2, 64'h0, 0, 0};
    vecs[4] = '{1'b1, 1'b0, 64'h20, 64'h0, 64'h0123456789ABCDEF, 16, 17, 16, 64'h0123456789ABCDEF, 0, 0};
`ifdef DMEM_ALIGN_CHECK_EN
    vecs[5] = '{1'b1, 1'b0, 64'h44, 64'h0, 64'h77, 1, 1, 0, 64'h0, 0, 1};
`else
    vecs[5] = '{1'b1, 1'b0, 64'h44, 64'h0, 64'h77, 1, 2, 1, 64'h77, 0, 0};
`endif
    vecs[6] = '{1'b1, 1'b0, 64'h28, 64'h0, 64'hCAFE, 15, 16, 15, 64'hCAFE, 0, 0};

    // Reset held two cycles with a load request pending.
    reset          = 1'b1;
    DM_readEnable  = 1'b1;
    DM_writeEnable = 1'b0;
    DM_addr        = 64'h40;
    DM_writeData   = '0;
    mem_ack        = 1'b0;
    mem_rdata      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("mem_req", {{(N-1){1'b0}}, mem_req}, '0);
    chk("mem_we", {{(N-1){1'b0}}, mem_we}, '0);
    chk("mem_addr", mem_addr, '0);
    chk("mem_wdata", mem_wdata, '0);
    chk("DM_readData", DM_readData, '0);
    chk("bus_error", {{(N-1){1'b0}}, bus_error}, '0);
    chk("misalign", {{(N-1){1'b0}}, misalign}, '0);
    reset         = 1'b0;
    DM_readEnable = 1'b0;
    #1;
    chk("stall_after_reset", {{(N-1){1'b0}}, stall}, '0);
    @(posedge clk); #1;
    chk("mem_req_after_reset", {{(N-1){1'b0}}, mem_req}, '0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    tag = "scoreboard";
    chk("leftover_requests", N'(req_q.size()), '0);

    // Stray ack while idle must be ignored.
    tag = "idle_ack";
    @(posedge clk); #1;
    mem_ack   = 1'b1;
    mem_rdata = 64'hBADBAD;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    #1;
    chk("mem_req", {{(N-1){1'b0}}, mem_req}, '0);
    chk("stall", {{(N-1){1'b0}}, stall}, '0);
    chk("DM_readData", DM_readData, 64'hCAFE);

    // Reset during the second REQ cycle abandons the access.
    tag = "mid_reset";
    @(posedge clk); #1;
    DM_readEnable = 1'b1;
    DM_addr       = 64'h30;
    @(posedge clk); #1;
    chk("mem_req_req1", {{(N-1){1'b0}}, mem_req}, {{(N-1){1'b0}}, 1'b1});
    @(posedge clk); #1;
    chk("mem_req_req2", {{(N-1){1'b0}}, mem_req}, {{(N-1){1'b0}}, 1'b1});
    reset         = 1'b1;
    DM_readEnable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mem_req_after", {{(N-1){1'b0}}, mem_req}, '0);
    chk("stall_after", {{(N-1){1'b0}}, stall}, '0);
    chk("DM_readData_after", DM_readData, '0);
    mem_ack   = 1'b1;
    mem_rdata = 64'hFEED;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    #1;
    chk("late_ack_mem_req", {{(N-1){1'b0}}, mem_req}, '0);
    chk("late_ack_stall", {{(N-1){1'b0}}, stall}, '0);
    chk("late_ack_readData", DM_readData, '0);
    be_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus_error) be_seen++;
    end
    chk("no_bus_error", N'(be_seen), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_controller.md
Name: dmem_controller

Overview:
- Data-memory access controller, directly downstream of the single-cycle datapath's DM port (DM_addr, DM_writeData, DM_writeEnable, DM_readEnable, DM_readData).
- Converts the datapath's zero-latency memory expectation into a req/ack handshake toward a variable-latency data memory.
- Asserts stall to freeze PC and register-file writeback until each access completes.
- Includes a timeout watchdog that reports a bus error.

Parameters:
- N, 64, data/address width (matches datapath N).
- TIMEOUT, 16, max cycles in REQ waiting for mem_ack before bus error; legal range 1..255.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- DM_addr  input  N  access address from datapath ALU result
- DM_writeData  input  N  store data from datapath
- DM_writeEnable  input  1  store request from datapath
- DM_readEnable  input  1  load request from datapath
- DM_readData  output  N  load data returned to datapath writeback
- stall  output  1  freezes PC/regWrite while high
- mem_req  output  1  request to memory, registered
- mem_we  output  1  1 = write, 0 = read, valid with mem_req
- mem_addr  output  N  latched address, valid with mem_req
- mem_wdata  output  N  latched store data, valid with mem_req
- mem_ack  input  1  one-cycle completion pulse from memory
- mem_rdata  input  N  read data, valid in the cycle mem_ack is high
- bus_error  output  1  one-cycle pulse on timeout
- misalign  output  1  one-cycle pulse on misaligned access (optional feature only)

Behaviour:
- Reset (sync, active-high) forces: state = IDLE; mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0; DM_readData = 0; bus_error = 0; misalign = 0; timeout counter = 0.
  - Reset mid-access abandons the access; mem_req is low from the next edge.
- State IDLE:
  - stall = DM_readEnable | DM_writeEnable, combinational, same cycle.
  - If either enable is high: latch DM_addr, DM_writeData and mem_we = DM_writeEnable; set mem_req = 1; clear counter; go to REQ.
  - Otherwise remain in IDLE.
- Simultaneous DM_readEnable and DM_writeEnable: treated as a write; DM_readData is not updated.
- State REQ:
  - stall = 1. mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - Counter increments each cycle.
  - mem_ack = 1: drop mem_req. For a read, DM_readData <= mem_rdata. Go to DONE.
  - Counter reaches TIMEOUT-1 without mem_ack: drop mem_req, pulse bus_error, DM_readData <= 0 for a read, go to DONE.
  - mem_ack in the same cycle as the timeout: ack wins, no bus_error.
- State DONE:
  - stall = 0, so the datapath completes the instruction using the registered DM_readData.
  - Unconditionally returns to IDLE next cycle. Enables seen in DONE belong to the finishing instruction and do not start a new access.
- Latency: access with ack arriving k cycles after mem_req rises (k >= 1) stalls for k+1 cycles; instruction retires in the DONE cycle.
- DM_readData holds its last value outside read completions.
- mem_ack while not in REQ is ignored.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - In IDLE with an enable high and DM_addr[2:0] != 0, no mem_req is issued.
  - misalign pulses for one cycle and the state goes directly to DONE; the stall lasts 1 cycle.
  - DM_readData <= 0 on a misaligned read; a misaligned write is dropped.
- Undefined:
  - No alignment check; the address is forwarded unmodified.
  - misalign is tied to 0.

Test Plan:
- Reset: assert reset 2 cycles while DM_readEnable = 1 -> all outputs 0, mem_req stays 0, state IDLE after release.
- Read with ack after 3 cycles: DM_readEnable = 1, DM_addr = 0x40, mem_rdata = 0xDEADBEEF at ack -> mem_req high 3 cycles with mem_addr = 0x40 and mem_we = 0; stall high 4 cycles; DM_readData = 0xDEADBEEF in DONE.
- Write with immediate ack: DM_writeEnable = 1, DM_addr = 0x08, DM_writeData = 0x1234 -> mem_req 1 cycle with mem_we = 1 and mem_wdata = 0x1234; DM_readData unchanged; stall 2 cycles.
- Timeout: read with mem_ack never asserted, TIMEOUT = 16 -> mem_req high 16 cycles; bus_error pulses once; DM_readData = 0; back to IDLE.
- Mid-access reset: reset pulsed in the 2nd REQ cycle -> mem_req low next edge; a later mem_ack is ignored; stall returns to 0.
- Alignment, with DMEM_ALIGN_CHECK_EN: DM_readEnable = 1, DM_addr = 0x44 -> no mem_req, misalign pulses once, stall 1 cycle, DM_readData = 0. Without the macro -> normal access to 0x44.
